hcsr04_medidor: RTL and testbench
=================================

// Module: hcsr04_medidor
// PURPOSE
//   HC-SR04 ultrasonic front end for the sonar system. On a measure request it
//   issues a 10 us trigger pulse and times the returned echo pulse. It converts
//   the echo width to centimetres, rounded to nearest, as 3 BCD digits.
//   It hands the distance to the sonar control/serial TX stage with a 1-cycle pronto.
// PARAMETERS
//   TRIGGER_CICLOS  500        trigger high time in clocks (10 us @ 50 MHz)
//   CICLOS_CM       2941       clocks per cm of distance (58.82 us @ 50 MHz)
//   MEIO_CM         1470       clocks to first cm increment (rounding offset)
//   TIMEOUT_CICLOS  1_500_000  max clocks from trigger fall to echo fall (30 ms)
// PORTS
//   clock      in   1   system clock, 50 MHz
//   reset      in   1   asynchronous, active-low reset
//   medir      in   1   start request, sampled high in INICIAL/FINAL/ERRO
//   echo       in   1   sensor echo, asynchronous to clock
//   trigger    out  1   sensor trigger pulse
//   medida     out  12  distance BCD {centenas,dezenas,unidades} in cm
//   pronto     out  1   1-cycle pulse: medida updated
//   timeout    out  1   1-cycle pulse: echo missing or too long
//   db_estado  out  4   current FSM state code
// BEHAVIOUR
// - reset low, any time including mid-measure: FSM->INICIAL; trigger=0,
//   medida=12'h000, pronto=0, timeout=0, all counters cleared.
// - echo passes a 2-FF synchronizer; all logic uses the synced copy
//   (2-cycle latency, absorbed by rounding margin).
// - FSM states / db_estado codes:
//   INICIAL(0): idle; medir=1 -> PREPARA.
//   PREPARA(1): clear trigger, cm, timeout counters; -> ENVIA_TRIGGER.
//   ENVIA_TRIGGER(2): trigger=1 for exactly TRIGGER_CICLOS clocks -> ESPERA_ECHO.
//   ESPERA_ECHO(3): wait synced echo rise -> MEDINDO.
//   MEDINDO(4): count while echo=1; echo fall -> ARMAZENA.
//   ARMAZENA(5): medida <= cm BCD count; -> FINAL.
//   FINAL(6): pronto=1 for this one cycle; medir=1 -> PREPARA, else -> INICIAL.
//   ERRO(F): timeout=1 for one cycle; medida unchanged; -> INICIAL.
// - In INICIAL, FINAL and ERRO, medir=1 starts a new cycle. ERRO always goes to
//   INICIAL next cycle, so a held medir restarts one cycle later.
//   medir in any other state is ignored (no queueing).
// - Timeout counter runs in ESPERA_ECHO and MEDINDO. It reaches TIMEOUT_CICLOS
//   -> ERRO; this has priority over a same-cycle echo edge.
// - Rounding: a sub-counter in MEDINDO fires first at MEIO_CM clocks, then
//   every CICLOS_CM clocks. Each fire increments a 3-digit BCD counter.
//   Result is round(width/CICLOS_CM).
// - BCD counter: unidades 9->0 carries dezenas; dezenas 9->0 carries centenas.
//   It saturates at 999 and never wraps.
// - Echo already high when ESPERA_ECHO is entered: rise is not detected. Wait
//   for the next rise, or time out.
// - Echo glitch shorter than MEIO_CM: measurement completes with medida=000.
// - medida holds its value between measurements. Only ARMAZENA writes it.
// TESTING
// 1. reset low 2 us, release, medir=1 pulse -> trigger high exactly 500 clocks,
//    starting 2 cycles after medir.
// 2. echo 6529 us after trigger fall+100 us -> pronto pulse, medida=12'h111;
//    then 12175 us -> 12'h207.
// 3. echo 1470/4705/4000/2647 us -> medida 12'h025/12'h080/12'h068/12'h045
//    (rounding boundaries).
// 4. no echo after trigger -> timeout pulse 1_500_000 clocks after trigger fall;
//    medida keeps the previous value; db_estado F then 0.
// 5. echo 70 ms (above timeout) -> timeout, no pronto. Separately, with
//    TIMEOUT_CICLOS raised to 4_000_000, echo 60 ms -> medida saturates at 12'h999.
// 6. reset low mid-MEDINDO -> trigger=0, medida=000, db_estado=0 asynchronously;
//    medir held high in FINAL -> back-to-back trigger with no INICIAL visit.

Source files
------------

// File: rtl/hcsr04_medidor_if.sv
// Signal bundle between the HC-SR04 front end and the sonar control stage.
// The slave side is the measurement block. The master side is the controller
// and sensor model that drives medir/echo and consumes the results.
interface hcsr04_medidor_if;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        timeout;
    logic [3:0]  db_estado;

    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  pronto,
        input  timeout,
        input  db_estado
    );

    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output pronto,
        output timeout,
        output db_estado
    );
endinterface

// File: rtl/hcsr04_medidor.sv
// HC-SR04 ultrasonic front end.
// A measure request fires a trigger pulse and then times the echo pulse.
// The echo width is converted on the fly into a 3-digit BCD centimetre count,
// rounded to nearest. A sub-counter fires first after half a centimetre and
// then once per centimetre, and each fire bumps the BCD digits.
module hcsr04_medidor #(
    parameter int TRIGGER_CICLOS = 500,
    parameter int CICLOS_CM      = 2941,
    parameter int MEIO_CM        = 1470,
    parameter int TIMEOUT_CICLOS = 1_500_000
) (
    input  logic            clock,
    input  logic            reset,
    hcsr04_medidor_if.slave bus
);
    localparam logic [3:0] INICIAL       = 4'h0;
    localparam logic [3:0] PREPARA       = 4'h1;
    localparam logic [3:0] ENVIA_TRIGGER = 4'h2;
    localparam logic [3:0] ESPERA_ECHO   = 4'h3;
    localparam logic [3:0] MEDINDO       = 4'h4;
    localparam logic [3:0] ARMAZENA      = 4'h5;
    localparam logic [3:0] FINAL         = 4'h6;
    localparam logic [3:0] ERRO          = 4'hF;

    localparam int SUB_MAX = (CICLOS_CM > MEIO_CM) ? CICLOS_CM : MEIO_CM;
    localparam int TRIG_W  = $clog2(TRIGGER_CICLOS + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CICLOS + 1);
    localparam int SUB_W   = $clog2(SUB_MAX + 1);

    localparam logic [TRIG_W-1:0] TRIG_ULT = TRIG_W'(TRIGGER_CICLOS - 1);
    localparam logic [TMO_W-1:0]  TMO_ULT  = TMO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [SUB_W-1:0]  MEIO_INI = SUB_W'(MEIO_CM - 1);
    localparam logic [SUB_W-1:0]  CM_INI   = SUB_W'(CICLOS_CM - 1);

    logic [3:0]        estado, proximo;
    logic              echo_s1, echo_s2, echo_d;
    logic [TRIG_W-1:0] cnt_trig;
    logic [TMO_W-1:0]  cnt_tmo;
    logic [SUB_W-1:0]  cnt_sub;
    logic [3:0]        unidades, dezenas, centenas;
    logic [11:0]       medida_q;

    logic sobe, desce, fim_trig, estourou, disparo, saturado;

    assign sobe     = echo_s2 & ~echo_d;
    assign desce    = ~echo_s2 & echo_d;
    assign fim_trig = (cnt_trig == TRIG_ULT);
    assign estourou = (cnt_tmo == TMO_ULT);
    assign disparo  = (estado == MEDINDO) && (cnt_sub == '0);
    assign saturado = ({centenas, dezenas, unidades} == 12'h999);

    // Bring the asynchronous echo into the clock domain and keep one more
    // stage so that edges can be seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, so the three stages shift instead of collapsing into one.
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // Next-state decision. A timeout wins over an echo edge in the same cycle.
    always_comb begin
        // NOTE: the default comes first, so every path assigns proximo and no
        // latch is inferred.
        proximo = estado;
        case (estado)
            INICIAL:       if (bus.medir) proximo = PREPARA;
            PREPARA:       proximo = ENVIA_TRIGGER;
            ENVIA_TRIGGER: if (fim_trig) proximo = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (estourou)  proximo = ERRO;
                else if (sobe) proximo = MEDINDO;
            end
            MEDINDO: begin
                if (estourou)   proximo = ERRO;
                else if (desce) proximo = ARMAZENA;
            end
            ARMAZENA:      proximo = FINAL;
            FINAL:         proximo = bus.medir ? PREPARA : INICIAL;
            ERRO:          proximo = INICIAL;
            default:       proximo = INICIAL;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    // Trigger, timeout and rounding counters, plus the BCD centimetre counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_trig <= '0;
            cnt_tmo  <= '0;
            cnt_sub  <= '0;
            unidades <= 4'd0;
            dezenas  <= 4'd0;
            centenas <= 4'd0;
        end else if (estado == PREPARA) begin
            cnt_trig <= '0;
            cnt_tmo  <= '0;
            cnt_sub  <= MEIO_INI;
            unidades <= 4'd0;
            dezenas  <= 4'd0;
            centenas <= 4'd0;
        end else begin
            if (estado == ENVIA_TRIGGER) cnt_trig <= cnt_trig + 1'b1;
            if (estado == ESPERA_ECHO || estado == MEDINDO) cnt_tmo <= cnt_tmo + 1'b1;
            if (estado == MEDINDO) begin
                cnt_sub <= (cnt_sub == '0) ? CM_INI : cnt_sub - 1'b1;
            end
            if (disparo && !saturado) begin
                if (unidades == 4'd9) begin
                    unidades <= 4'd0;
                    if (dezenas == 4'd9) begin
                        dezenas  <= 4'd0;
                        centenas <= centenas + 1'b1;
                    end else begin
                        dezenas <= dezenas + 1'b1;
                    end
                end else begin
                    unidades <= unidades + 1'b1;
                end
            end
        end
    end

    // Result register. It changes only when a completed measurement is stored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  medida_q <= 12'h000;
        else if (estado == ARMAZENA) medida_q <= {centenas, dezenas, unidades};
    end

    assign bus.trigger   = (estado == ENVIA_TRIGGER);
    assign bus.pronto    = (estado == FINAL);
    assign bus.timeout   = (estado == ERRO);
    assign bus.medida    = medida_q;
    assign bus.db_estado = estado;
endmodule

// File: tb/tb_hcsr04_medidor.sv
// Directed bench for hcsr04_medidor, built with scaled-down timing:
// trigger 10 clocks, 8 clocks/cm, first fire at 4 clocks, timeout 10000 clocks.
// An echo of W clocks must give floor((W + 4) / 8) cm, which is round-half-up of W/8.
module tb_hcsr04_medidor;
    localparam int TRIG = 10;
    localparam int TMO  = 10000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hcsr04_medidor_if bus ();

    hcsr04_medidor #(
        .TRIGGER_CICLOS(TRIG),
        .CICLOS_CM     (8),
        .MEIO_CM       (4),
        .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clock);
        bus.medir = 1'b1;
        @(negedge clock);
        bus.medir = 1'b0;
    endtask

    // Wait for trigger to rise, measure its width, and return on the negedge just after it falls.
    task automatic pulso_trigger(input string tag);
        int n = 0;
        int altos = 0;
        while (!bus.trigger && n < 50) begin
            @(negedge clock);
            n++;
        end
        while (bus.trigger && altos < 1000) begin
            altos++;
            @(negedge clock);
        end
        check(tag, altos, TRIG);
    endtask

    task automatic eco(input int atraso, input int largura);
        repeat (atraso) @(negedge clock);
        bus.echo = 1'b1;
        repeat (largura) @(negedge clock);
        bus.echo = 1'b0;
    endtask

    task automatic espera_pronto(input string tag, input logic [11:0] esperado,
                                 input logic [3:0] estado_seguinte);
        int n = 0;
        while (!bus.pronto && !bus.timeout && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
        check({tag, "_medida"}, 32'(bus.medida), 32'(esperado));
        @(negedge clock);
        check({tag, "_pronto_1ciclo"}, 32'(bus.pronto), 32'd0);
        check({tag, "_estado_seguinte"}, 32'(bus.db_estado), 32'(estado_seguinte));
    endtask

    task automatic medicao(input string tag, input int largura, input logic [11:0] esperado);
        start_pulse();
        pulso_trigger({tag, "_trigger"});
        eco(5, largura);
        espera_pronto(tag, esperado, 4'h0);
    endtask

    // Watchdog in case a bounded wait is ever bypassed.
    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int prontos;
        logic viu_timeout;

        bus.medir = 1'b0;
        bus.echo  = 1'b0;

        // Reset held for 100 clocks (2 us).
        repeat (100) @(negedge clock);
        check("rst_trigger", 32'(bus.trigger), 32'd0);
        check("rst_medida", 32'(bus.medida), 32'h000);
        check("rst_pronto", 32'(bus.pronto), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_estado", 32'(bus.db_estado), 32'h0);
        reset = 1'b1;

        // Trigger starts two cycles after medir and lasts exactly TRIG clocks.
        @(negedge clock);
        bus.medir = 1'b1;
        @(negedge clock);
        bus.medir = 1'b0;
        check("t1_estado_prepara", 32'(bus.db_estado), 32'h1);
        check("t1_trigger_ainda_0", 32'(bus.trigger), 32'd0);
        @(negedge clock);
        check("t1_trigger_sobe", 32'(bus.trigger), 32'd1);
        n = 0;
        while (bus.trigger && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("t1_trigger_largura", n, TRIG);
        check("t1_espera_echo", 32'(bus.db_estado), 32'h3);
        eco(5, 888);
        espera_pronto("m111", 12'h111, 4'h0);

        medicao("m207", 1656, 12'h207);

        // Rounding boundaries and BCD carries.
        medicao("m025", 196, 12'h025);
        medicao("m024", 195, 12'h024);
        medicao("m080", 636, 12'h080);
        medicao("m079", 635, 12'h079);
        medicao("m100", 796, 12'h100);
        medicao("m099", 795, 12'h099);
        medicao("m001", 4,   12'h001);
        medicao("m000a", 3,  12'h000);
        medicao("m000b", 1,  12'h000);

        // Echo already high when waiting starts: no rise yet, keep waiting.
        bus.echo = 1'b1;
        start_pulse();
        pulso_trigger("alto_trigger");
        repeat (50) @(negedge clock);
        check("alto_sem_subida", 32'(bus.db_estado), 32'h3);
        bus.echo = 1'b0;
        eco(5, 196);
        espera_pronto("alto", 12'h025, 4'h0);

        // medir pulsed during MEDINDO is ignored.
        start_pulse();
        pulso_trigger("ign_trigger");
        repeat (5) @(negedge clock);
        bus.echo = 1'b1;
        repeat (100) @(negedge clock);
        bus.medir = 1'b1;
        @(negedge clock);
        bus.medir = 1'b0;
        check("ign_medindo", 32'(bus.db_estado), 32'h4);
        repeat (535) @(negedge clock);
        bus.echo = 1'b0;
        espera_pronto("ign", 12'h080, 4'h0);

        // No echo: timeout exactly TMO clocks after the trigger falls.
        start_pulse();
        pulso_trigger("tmo_trigger");
        n = 0;
        while (!bus.timeout && n < 20000) begin
            @(negedge clock);
            n++;
        end
        check("tmo_ciclos", n, TMO);
        check("tmo_estado_F", 32'(bus.db_estado), 32'hF);
        check("tmo_sem_pronto", 32'(bus.pronto), 32'd0);
        check("tmo_medida_mantida", 32'(bus.medida), 32'h080);
        @(negedge clock);
        check("tmo_pulso_1ciclo", 32'(bus.timeout), 32'd0);
        check("tmo_estado_0", 32'(bus.db_estado), 32'h0);

        // Echo longer than the timeout: timeout, never pronto.
        start_pulse();
        pulso_trigger("longo_trigger");
        repeat (5) @(negedge clock);
        bus.echo    = 1'b1;
        prontos     = 0;
        viu_timeout = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clock);
            if (bus.pronto)  prontos++;
            if (bus.timeout) viu_timeout = 1'b1;
        end
        bus.echo = 1'b0;
        check("longo_timeout", 32'(viu_timeout), 32'd1);
        check("longo_sem_pronto", prontos, 0);
        check("longo_medida_mantida", 32'(bus.medida), 32'h080);

        // Saturation: 9000 clocks is 1125 cm, clamped to 999.
        medicao("sat", 9000, 12'h999);

        // Asynchronous reset in the middle of a measurement.
        start_pulse();
        pulso_trigger("rstm_trigger");
        repeat (5) @(negedge clock);
        bus.echo = 1'b1;
        repeat (50) @(negedge clock);
        check("rstm_medindo", 32'(bus.db_estado), 32'h4);
        #3;
        reset = 1'b0;
        #1;
        check("rstm_trigger", 32'(bus.trigger), 32'd0);
        check("rstm_medida", 32'(bus.medida), 32'h000);
        check("rstm_estado", 32'(bus.db_estado), 32'h0);
        check("rstm_pronto", 32'(bus.pronto), 32'd0);
        bus.echo = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // medir held high through FINAL: back-to-back measurement without INICIAL.
        @(negedge clock);
        bus.medir = 1'b1;
        pulso_trigger("b2b1_trigger");
        eco(5, 888);
        espera_pronto("b2b1", 12'h111, 4'h1);
        bus.medir = 1'b0;
        pulso_trigger("b2b2_trigger");
        eco(5, 1656);
        espera_pronto("b2b2", 12'h207, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
